// File: rtl/alu_unit_pkg.sv
// Shared opcode encodings, default widths and decode class for the ALU execution unit.
// The MUL-family encodings always exist here; alu_unit only decodes them when ALU_UNIT_MUL_EN is defined.
package alu_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;
  localparam int OP_W_DEF  = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [OP_W_DEF-1:0] OP_ADD    = 6'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB    = 6'd1;
  localparam logic [OP_W_DEF-1:0] OP_XOR    = 6'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR     = 6'd3;
  localparam logic [OP_W_DEF-1:0] OP_AND    = 6'd4;
  localparam logic [OP_W_DEF-1:0] OP_SLL    = 6'd5;
  localparam logic [OP_W_DEF-1:0] OP_SRL    = 6'd6;
  localparam logic [OP_W_DEF-1:0] OP_SRA    = 6'd7;
  localparam logic [OP_W_DEF-1:0] OP_SLT    = 6'd8;
  localparam logic [OP_W_DEF-1:0] OP_SLTU   = 6'd9;
  localparam logic [OP_W_DEF-1:0] OP_ADDI   = 6'd10;
  localparam logic [OP_W_DEF-1:0] OP_XORI   = 6'd11;
  localparam logic [OP_W_DEF-1:0] OP_ORI    = 6'd12;
  localparam logic [OP_W_DEF-1:0] OP_ANDI   = 6'd13;
  localparam logic [OP_W_DEF-1:0] OP_SLLI   = 6'd14;
  localparam logic [OP_W_DEF-1:0] OP_SRLI   = 6'd15;
  localparam logic [OP_W_DEF-1:0] OP_SRAI   = 6'd16;
  localparam logic [OP_W_DEF-1:0] OP_SLTI   = 6'd17;
  localparam logic [OP_W_DEF-1:0] OP_SLTIU  = 6'd18;
  localparam logic [OP_W_DEF-1:0] OP_BEQ    = 6'd19;
  localparam logic [OP_W_DEF-1:0] OP_BNE    = 6'd20;
  localparam logic [OP_W_DEF-1:0] OP_BLT    = 6'd21;
  localparam logic [OP_W_DEF-1:0] OP_BGE    = 6'd22;
  localparam logic [OP_W_DEF-1:0] OP_BLTU   = 6'd23;
  localparam logic [OP_W_DEF-1:0] OP_BGEU   = 6'd24;
  localparam logic [OP_W_DEF-1:0] OP_JALR   = 6'd25;
  localparam logic [OP_W_DEF-1:0] OP_MUL    = 6'd26;
  localparam logic [OP_W_DEF-1:0] OP_MULH   = 6'd27;
  localparam logic [OP_W_DEF-1:0] OP_MULHSU = 6'd28;
  localparam logic [OP_W_DEF-1:0] OP_MULHU  = 6'd29;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_ALU    = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_JUMP   = 2'd3
  } op_class_e;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order DEPTH-entry result queue; push writes tail on the edge, head is visible the next cycle.
// Full blocks push regardless of a same-cycle pop; flush and reset empty it; rdy low freezes it.
module alu_result_fifo #(
  parameter int W     = 70,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         push,
  input  logic         pop_req,
  input  logic [W-1:0] push_entry,
  output logic [W-1:0] head_entry,
  output logic         valid,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          pop;

  assign valid      = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign pop        = valid && pop_req && rdy;
  assign head_entry = mem[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle integer ALU feeding an in-order CDB result queue; result on cdb_* one cycle after accept.
// in_ready drops when full, on flush or when rdy is low; MUL family is built only with ALU_UNIT_MUL_EN.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ROB_W = ROB_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_opcode,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [XLEN-1:0]  in_lhs,
  input  logic [XLEN-1:0]  in_rhs,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  cdb_result,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [XLEN-1:0]  cdb_target,
  output logic             cdb_jump,
  output logic             cdb_taken
);

  localparam int SH_W = $clog2(XLEN);
  localparam int EW   = 2 * XLEN + ROB_W + 2;

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            cond;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  op_class_e       cls;
  logic            full;
  logic            push;
  logic [EW-1:0]   push_entry;
  logic [EW-1:0]   head_entry;

`ifdef ALU_UNIT_MUL_EN
  logic [2*XLEN-1:0] prod_uu;
  logic [2*XLEN-1:0] prod_ss;
  logic [2*XLEN-1:0] prod_su;

  // Double-width products of extended operands; the high half selects the signedness variant.
  assign prod_uu = {{XLEN{1'b0}}, in_lhs} * {{XLEN{1'b0}}, in_rhs};
  assign prod_ss = {{XLEN{in_lhs[XLEN-1]}}, in_lhs} * {{XLEN{in_rhs[XLEN-1]}}, in_rhs};
  assign prod_su = {{XLEN{in_lhs[XLEN-1]}}, in_lhs} * {{XLEN{1'b0}}, in_rhs};
`endif

  assign shamt    = in_rhs[SH_W-1:0];
  assign lt_s     = ($signed(in_lhs) < $signed(in_rhs));
  assign lt_u     = (in_lhs < in_rhs);
  assign eq       = (in_lhs == in_rhs);
  assign jalr_sum = in_lhs + in_imm;

  always_comb begin
    result = '0;
    cond   = FALSE;
    cls    = CLS_NONE;
    case (in_opcode)
      OP_ADD,  OP_ADDI:  begin result = in_lhs + in_rhs;              cls = CLS_ALU; end
      OP_SUB:            begin result = in_lhs - in_rhs;              cls = CLS_ALU; end
      OP_XOR,  OP_XORI:  begin result = in_lhs ^ in_rhs;              cls = CLS_ALU; end
      OP_OR,   OP_ORI:   begin result = in_lhs | in_rhs;              cls = CLS_ALU; end
      OP_AND,  OP_ANDI:  begin result = in_lhs & in_rhs;              cls = CLS_ALU; end
      OP_SLL,  OP_SLLI:  begin result = in_lhs << shamt;              cls = CLS_ALU; end
      OP_SRL,  OP_SRLI:  begin result = in_lhs >> shamt;              cls = CLS_ALU; end
      OP_SRA,  OP_SRAI:  begin result = $signed(in_lhs) >>> shamt;    cls = CLS_ALU; end
      OP_SLT,  OP_SLTI:  begin result = {{(XLEN-1){1'b0}}, lt_s};     cls = CLS_ALU; end
      OP_SLTU, OP_SLTIU: begin result = {{(XLEN-1){1'b0}}, lt_u};     cls = CLS_ALU; end
      OP_BEQ:            begin cond = eq;    cls = CLS_BRANCH; end
      OP_BNE:            begin cond = !eq;   cls = CLS_BRANCH; end
      OP_BLT:            begin cond = lt_s;  cls = CLS_BRANCH; end
      OP_BGE:            begin cond = !lt_s; cls = CLS_BRANCH; end
      OP_BLTU:           begin cond = lt_u;  cls = CLS_BRANCH; end
      OP_BGEU:           begin cond = !lt_u; cls = CLS_BRANCH; end
      OP_JALR:           begin result = in_pc + XLEN'(4);             cls = CLS_JUMP; end
`ifdef ALU_UNIT_MUL_EN
      OP_MUL:            begin result = prod_uu[XLEN-1:0];            cls = CLS_ALU; end
      OP_MULH:           begin result = XLEN'(prod_ss >> XLEN);       cls = CLS_ALU; end
      OP_MULHSU:         begin result = XLEN'(prod_su >> XLEN);       cls = CLS_ALU; end
      OP_MULHU:          begin result = XLEN'(prod_uu >> XLEN);       cls = CLS_ALU; end
`endif
      default: ;
    endcase
    if (cls == CLS_BRANCH) result = {{(XLEN-1){1'b0}}, cond};
  end

  always_comb begin
    target = '0;
    if (cls == CLS_BRANCH)    target = in_pc + in_imm;
    else if (cls == CLS_JUMP) target = jalr_sum & ~XLEN'(1);
  end

  // Ready ignores cdb_grant so there is no combinational grant->ready path.
  assign in_ready   = rdy && !flush && !full;
  assign push       = in_valid && in_ready;
  assign push_entry = {result, in_rob, target, (cls == CLS_JUMP), (cls == CLS_BRANCH) && cond};

  alu_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .push       (push),
    .pop_req    (cdb_grant),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .valid      (cdb_valid),
    .full       (full)
  );

  assign {cdb_result, cdb_rob, cdb_target, cdb_jump, cdb_taken} = head_entry;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Parametrised integer execution unit sitting between the ALU reservation station and the CDB.
- Accepts one issued op per cycle over a valid/ready handshake and computes a result, plus a branch/jump target.
- Results are buffered in an in-order result queue of depth DEPTH and drained onto the CDB under a grant handshake.
- Performs squash on ROB flush; JALR/branch redirect information is carried to IF with the result.

Parameters:
- XLEN, 32, operand/result/pc width.
- ROB_W, 4, ROB tag width.
- OP_W, 6, opcode width (encodings in shared package).
- DEPTH, 4, result queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  ROB misprediction clear.
- in_valid  in  1  RS issues an op.
- in_ready  out  1  unit can accept this cycle.
- in_opcode  in  OP_W  operation.
- in_rob  in  ROB_W  destination ROB tag.
- in_lhs  in  XLEN  rs1 value.
- in_rhs  in  XLEN  rs2 value or immediate.
- in_pc  in  XLEN  instruction pc.
- in_imm  in  XLEN  branch/JALR offset.
- cdb_valid  out  1  head entry present.
- cdb_grant  in  1  CDB consumes head this cycle.
- cdb_result  out  XLEN  head result.
- cdb_rob  out  ROB_W  head tag.
- cdb_target  out  XLEN  redirect target of head.
- cdb_jump  out  1  head is JALR (IF must redirect to cdb_target).
- cdb_taken  out  1  head is a taken conditional branch.

Behaviour:
- Reset (rst low, async): queue empty, head=tail=count=0, cdb_valid=0. cdb_result/rob/target/jump/taken read 0 (queue storage cleared).
- in_ready = rdy && !flush && (count < DEPTH). No dependence on cdb_grant (no comb path grant->ready).
- Accept = in_valid && in_ready. The result is computed combinationally and written at the tail on the same edge.
- Latency: the entry is visible on cdb_* the cycle after accept when the queue was empty.
- Arithmetic, result field:
  - ADD/ADDI lhs+rhs; SUB lhs-rhs; XOR/OR/AND and immediate forms bitwise.
  - SLL/SRL/SRA and immediate forms shift by rhs[4:0]; SRA is arithmetic.
  - SLT/SLTI signed compare; SLTU/SLTIU unsigned compare; result 0/1 zero-extended.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result = condition (0/1).
  - JALR: result = in_pc+4 (link value).
  - Unknown opcode: result 0, jump 0, taken 0; entry is still written.
- target field:
  - Branches: in_pc+in_imm.
  - JALR: (in_lhs+in_imm) & ~1.
  - Otherwise 0.
  - All sums wrap modulo 2^XLEN.
- jump field = 1 only for JALR. taken field = condition, for branches only.
- cdb_valid = (count != 0). Pop = cdb_valid && cdb_grant && rdy; advances head.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
- Full (count==DEPTH): in_ready=0, even if pop occurs that cycle.
- Empty: cdb_grant is ignored.
- flush=1 (sampled at edge, rdy-independent):
  - head=tail=count=0, so cdb_valid=0 next cycle.
  - Any in_valid that cycle is dropped (in_ready already 0).
  - Any pop that cycle is discarded.
- rdy=0: no push, no pop, outputs hold.
- Reset mid-operation: queue contents are lost immediately, regardless of rdy.

Optional Feature:
- Macro ALU_UNIT_MUL_EN.
- Defined: adds opcodes MUL (low XLEN), MULH (signed x signed high), MULHSU (signed x unsigned high) and MULHU (unsigned high). All are computed in the same single cycle and queued like other ops.
- Not defined: those opcodes decode as unknown (result 0).

Decomposition:
- Shared package/defines: opcode constants (including MUL family), OP_W, XLEN, ROB_W, and the True/False constants.
- One natural sub-module: alu_result_fifo (DEPTH-entry circular queue with push/pop/flush, count, and a packed entry of {result, rob, target, jump, taken}).
- The compute datapath stays in alu_unit.

Test Plan:
- ADD lhs=0x7FFFFFFF rhs=1, rob=3, grant held 1 -> next cycle cdb_valid=1, result=0x80000000, rob=3, jump=0, taken=0; popped.
- SRA lhs=0x80000010 rhs=0x24; SLTU lhs=1 rhs=0xFFFFFFFF -> results 0xF8000001, then 1, in issue order.
- JALR pc=0x100 lhs=0x2001 imm=4 -> result=0x104, target=0x2004, jump=1.
- BGE pc=0x40 imm=-8, lhs=-1 rhs=-1 -> result=1, taken=1, target=0x38.
- Grant=0, issue 5 ops with DEPTH=4 -> in_ready=0 after 4th accept, 5th held. Grant=1 with 5th valid -> pop without same-cycle accept; 5th accepted next cycle; order preserved.
- Queue holding 3 entries, assert flush with in_valid=1 -> next cycle cdb_valid=0, count=0, new op not recorded. Also: rst low mid-stream -> immediate cdb_valid=0.
